// File: rtl/operand_writeback.sv
// ============================================================================
// Module   : operand_writeback
// Purpose  : Decodes the destination field of a fetched instruction and stores
//            the result to the register file or to memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module operand_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [47:0]       inst,
  input  logic [DATA_W-1:0] result,
  output logic [RIDX_W-1:0] reg_rd_idx,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              reg_we,
  output logic [RIDX_W-1:0] reg_wr_idx,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IDX_RD = 3'd1,
    WR_REG = 3'd2,
    WR_MEM = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_IDX = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                wb_ready_q, wb_ready_d;
  logic [RIDX_W-1:0]   reg_rd_idx_q, reg_rd_idx_d;
  logic                reg_we_q, reg_we_d;
  logic [RIDX_W-1:0]   reg_wr_idx_q, reg_wr_idx_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Opcode words and the high byte of the index register play no part here.
  logic unused_bits;
  assign unused_bits = ^{inst[47:18], reg_rd_data[DATA_W-1:ADDR_W]};

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    reg_rd_idx_d = reg_rd_idx_q;
    reg_wr_idx_d = reg_wr_idx_q;
    reg_wdata_d  = reg_wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          case (inst[17:16])
            MODE_REG: begin
              state_d      = WR_REG;
              reg_wr_idx_d = inst[3:0];
              reg_wdata_d  = result;
            end
            MODE_MEM: begin
              state_d     = WR_MEM;
              mem_addr_d  = inst[15:8];
              mem_wdata_d = result;
            end
            MODE_IDX: begin
              state_d      = IDX_RD;
              reg_rd_idx_d = inst[7:4];
              base_d       = inst[15:8];
              mem_wdata_d  = result;
            end
            default: state_d = ERR;
          endcase
        end
      end
      IDX_RD: begin
        // Carry out of the address sum is dropped: the address space wraps.
        mem_addr_d = base_q + reg_rd_data[ADDR_W-1:0];
        state_d    = WR_MEM;
      end
      WR_REG:  state_d = DONE;
      WR_MEM:  state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status and strobes are decoded from the next state so they register in step with it.
    wb_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    reg_we_d   = (state_d == WR_REG);
    mem_we_d   = (state_d == WR_MEM);
    done_d     = (state_d == DONE) || (state_d == ERR);
    err_d      = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      base_q       <= '0;
      wb_ready_q   <= 1'b1;
      reg_rd_idx_q <= '0;
      reg_we_q     <= 1'b0;
      reg_wr_idx_q <= '0;
      reg_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      wb_ready_q   <= wb_ready_d;
      reg_rd_idx_q <= reg_rd_idx_d;
      reg_we_q     <= reg_we_d;
      reg_wr_idx_q <= reg_wr_idx_d;
      reg_wdata_q  <= reg_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign wb_ready   = wb_ready_q;
  assign reg_rd_idx = reg_rd_idx_q;
  assign reg_we     = reg_we_q;
  assign reg_wr_idx = reg_wr_idx_q;
  assign reg_wdata  = reg_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_writeback.sv
// ============================================================================
// Module   : tb_operand_writeback
// Purpose  : Directed self-checking bench for operand_writeback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_operand_writeback;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_valid;
  logic        wb_ready;
  logic [47:0] inst;
  logic [15:0] result;
  logic [3:0]  reg_rd_idx;
  logic [15:0] reg_rd_data;
  logic        reg_we;
  logic [3:0]  reg_wr_idx;
  logic [15:0] reg_wdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] regfile [16];
  int total  = 0;
  int passed = 0;
  int reg_we_cnt = 0, mem_we_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  always #5 clk = ~clk;

  assign reg_rd_data = regfile[reg_rd_idx];

  operand_writeback dut (
    .clk(clk), .clr(clr), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .inst(inst), .result(result), .reg_rd_idx(reg_rd_idx), .reg_rd_data(reg_rd_data),
    .reg_we(reg_we), .reg_wr_idx(reg_wr_idx), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (reg_we) reg_we_cnt <= reg_we_cnt + 1;
    if (mem_we) mem_we_cnt <= mem_we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (reg_we && mem_we) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; wb_valid = 1'b0; inst = '0; result = '0;
    tick(); tick();
    clr = 1'b0;
    total++; if (wb_ready !== 1'b1) $display("FAIL reset_wb_ready got=%b exp=1", wb_ready); else passed++;
    total++; if ({busy, done, err, reg_we, mem_we} !== 5'b0) $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, err, reg_we, mem_we}); else passed++;
    total++; if ({mem_addr, mem_wdata, reg_wdata, reg_wr_idx, reg_rd_idx} !== '0) $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, reg_wdata, reg_wr_idx, reg_rd_idx}); else passed++;
  endtask

  task automatic test_reg_direct();
    int r0 = reg_we_cnt, m0 = mem_we_cnt;
    inst = 48'h0000_0000_0005; result = 16'hBEEF; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;                        // cycle N+1
    total++; if (reg_we !== 1'b1 || mem_we !== 1'b0) $display("FAIL regd_we got=%b%b exp=10", reg_we, mem_we); else passed++;
    total++; if (reg_wr_idx !== 4'd5 || reg_wdata !== 16'hBEEF) $display("FAIL regd_data got=%h/%h exp=5/beef", reg_wr_idx, reg_wdata); else passed++;
    total++; if (busy !== 1'b1 || wb_ready !== 1'b0 || done !== 1'b0) $display("FAIL regd_busy got=%b%b%b exp=100", busy, wb_ready, done); else passed++;
    tick();                                         // N+2
    total++; if (done !== 1'b1 || err !== 1'b0 || reg_we !== 1'b0) $display("FAIL regd_done got=%b%b%b exp=100", done, err, reg_we); else passed++;
    tick();                                         // N+3
    total++; if (wb_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL regd_idle got=%b%b%b exp=100", wb_ready, busy, done); else passed++;
    total++; if (reg_we_cnt - r0 != 1 || mem_we_cnt - m0 != 0) $display("FAIL regd_counts got=%0d/%0d exp=1/0", reg_we_cnt - r0, mem_we_cnt - m0); else passed++;
  endtask

  task automatic test_mem_direct();
    inst = 48'h0000_0001_4000; result = 16'h1234; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;                        // N+1
    total++; if (mem_we !== 1'b1 || reg_we !== 1'b0) $display("FAIL memd_we got=%b%b exp=10", mem_we, reg_we); else passed++;
    total++; if (mem_addr !== 8'h40 || mem_wdata !== 16'h1234) $display("FAIL memd_data got=%h/%h exp=40/1234", mem_addr, mem_wdata); else passed++;
    tick();                                         // N+2
    total++; if (done !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h40) $display("FAIL memd_done got=%b%b/%h exp=10/40", done, mem_we, mem_addr); else passed++;
    tick();
  endtask

  task automatic test_indexed(input logic [7:0] base, input logic [3:0] ridx,
                              input logic [15:0] rval, input logic [15:0] res,
                              input logic [7:0] exp_addr);
    regfile[ridx] = rval;
    inst = {16'h0000, 16'h0002, base, ridx, 4'h0}; result = res; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;                        // N+1
    total++; if (reg_rd_idx !== ridx || mem_we !== 1'b0 || busy !== 1'b1) $display("FAIL idx_rd got=%h/%b%b exp=%h/01", reg_rd_idx, mem_we, busy, ridx); else passed++;
    tick();                                         // N+2
    total++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== res) $display("FAIL idx_wr got=%b/%h/%h exp=1/%h/%h", mem_we, mem_addr, mem_wdata, exp_addr, res); else passed++;
    tick();                                         // N+3
    total++; if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) $display("FAIL idx_done got=%b%b%b exp=100", done, err, mem_we); else passed++;
    tick();
  endtask

  task automatic test_illegal();
    int r0 = reg_we_cnt, m0 = mem_we_cnt;
    inst = 48'h0000_0003_1234; result = 16'hDEAD; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;                        // N+1
    total++; if (done !== 1'b1 || err !== 1'b1 || reg_we !== 1'b0 || mem_we !== 1'b0) $display("FAIL ill_pulse got=%b%b%b%b exp=1100", done, err, reg_we, mem_we); else passed++;
    tick();                                         // N+2
    total++; if (wb_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) $display("FAIL ill_after got=%b%b%b exp=100", wb_ready, done, err); else passed++;
    total++; if (reg_we_cnt - r0 != 0 || mem_we_cnt - m0 != 0) $display("FAIL ill_counts got=%0d/%0d exp=0/0", reg_we_cnt - r0, mem_we_cnt - m0); else passed++;
  endtask

  task automatic test_back_to_back();
    int r0 = reg_we_cnt;
    inst = 48'h0000_0000_0002; result = 16'h1111; wb_valid = 1'b1;
    tick();                                         // N+1, valid stays high with a new request
    inst = 48'h0000_0000_0009; result = 16'h2222;
    total++; if (reg_we !== 1'b1 || reg_wr_idx !== 4'd2 || reg_wdata !== 16'h1111) $display("FAIL b2b_first got=%b/%h/%h exp=1/2/1111", reg_we, reg_wr_idx, reg_wdata); else passed++;
    tick();                                         // N+2
    total++; if (done !== 1'b1 || reg_wr_idx !== 4'd2 || reg_wdata !== 16'h1111) $display("FAIL b2b_hold got=%b/%h/%h exp=1/2/1111", done, reg_wr_idx, reg_wdata); else passed++;
    tick();                                         // N+3, first idle cycle
    total++; if (wb_ready !== 1'b1 || reg_we !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle got=%b%b%b exp=100", wb_ready, reg_we, busy); else passed++;
    tick(); wb_valid = 1'b0;                        // N+4
    total++; if (reg_we !== 1'b1 || reg_wr_idx !== 4'd9 || reg_wdata !== 16'h2222) $display("FAIL b2b_second got=%b/%h/%h exp=1/9/2222", reg_we, reg_wr_idx, reg_wdata); else passed++;
    tick(); tick();
    total++; if (reg_we_cnt - r0 != 2) $display("FAIL b2b_count got=%0d exp=2", reg_we_cnt - r0); else passed++;
  endtask

  task automatic test_reset_mid();
    int m0 = mem_we_cnt, d0 = done_cnt;
    regfile[4] = 16'h0010;
    inst = {16'h0000, 16'h0002, 8'h30, 4'h4, 4'h0}; result = 16'hCAFE; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;                        // N+1
    clr = 1'b1;
    tick(); clr = 1'b0;                             // after edge N+1
    total++; if (busy !== 1'b0 || wb_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid got=%b%b%b%b exp=0100", busy, wb_ready, mem_we, done); else passed++;
    tick(); tick(); tick();
    total++; if (mem_we_cnt - m0 != 0 || done_cnt - d0 != 0) $display("FAIL rst_mid_counts got=%0d/%0d exp=0/0", mem_we_cnt - m0, done_cnt - d0); else passed++;
    inst = 48'h0000_0001_7700; result = 16'h5A5A; wb_valid = 1'b1;
    tick(); wb_valid = 1'b0;
    total++; if (mem_we !== 1'b1 || mem_addr !== 8'h77 || mem_wdata !== 16'h5A5A) $display("FAIL rst_fresh got=%b/%h/%h exp=1/77/5a5a", mem_we, mem_addr, mem_wdata); else passed++;
    tick();
    total++; if (done !== 1'b1) $display("FAIL rst_fresh_done got=%b exp=1", done); else passed++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regfile[i] = 16'h0;
    test_reset();
    test_reg_direct();
    test_mem_direct();
    test_indexed(8'hF0, 4'd3, 16'h0025, 16'hA5A5, 8'h15);
    test_indexed(8'h20, 4'd7, 16'h1203, 16'h0F0F, 8'h23);
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    total++; if (overlap_cnt != 0) $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
